// File: rtl/read_returner.sv
// ----------------------------------------------------------------------------
// read_returner
//
// Reorder stage sitting directly behind the back end's burst handler. Read
// data comes back out of order, tagged with the read index it belongs to.
// This block parks each beat in a small reorder memory and hands it to the
// front end strictly in allocation order through a valid/ready handshake.
// It also owns the pool of read indices: the front end asks for an index
// before issuing a read, and gets it back once the data has drained.
// Write completions pass straight through as single-cycle pulses.
//
// Parameters
//   DATA_BITS     width of one read data beat
//   READ_ENTRIES  reorder depth, must be a power of two (pointers wrap freely)
//
// Ports
//   i_clk            single clock, rising edge
//   i_rst_n          asynchronous active-low reset
//   i_alloc_valid    front end requests a read index
//   o_alloc_ready    an index is free (fewer than READ_ENTRIES outstanding)
//   o_alloc_index    index granted on an i_alloc_valid & o_alloc_ready cycle
//   i_in_valid       returning beat from the burst handler
//   i_in_type        beat type: 0 = read data, 1 = write completion
//   i_in_data        returning read data
//   i_in_index       read/write index the beat belongs to
//   o_out_valid      in-order read data available at the head
//   i_out_ready      front end accepts o_out_data
//   o_out_data       read data for o_out_index
//   o_out_index      index of the head entry
//   o_wr_done_valid  one-cycle write completion pulse
//   o_wr_done_index  index of the completed write (held between pulses)
//   o_err_fill       sticky; a fill hit a non-pending or already-filled entry
// ----------------------------------------------------------------------------
module read_returner #(
    parameter int DATA_BITS    = 16,
    parameter int READ_ENTRIES = 64
) (
    input  logic                              i_clk,
    input  logic                              i_rst_n,
    input  logic                              i_alloc_valid,
    output logic                              o_alloc_ready,
    output logic [$clog2(READ_ENTRIES)-1:0]   o_alloc_index,
    input  logic                              i_in_valid,
    input  logic                              i_in_type,
    input  logic [DATA_BITS-1:0]              i_in_data,
    input  logic [$clog2(READ_ENTRIES)-1:0]   i_in_index,
    output logic                              o_out_valid,
    input  logic                              i_out_ready,
    output logic [DATA_BITS-1:0]              o_out_data,
    output logic [$clog2(READ_ENTRIES)-1:0]   o_out_index,
    output logic                              o_wr_done_valid,
    output logic [$clog2(READ_ENTRIES)-1:0]   o_wr_done_index,
    output logic                              o_err_fill
);

    localparam int             IW         = $clog2(READ_ENTRIES);
    localparam logic [IW:0]    FULL_COUNT = (IW+1)'(READ_ENTRIES);
    localparam logic           TYPE_READ  = 1'b0;
    localparam logic           TYPE_WRITE = 1'b1;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [IW-1:0]           r_alloc_ptr;
    logic [IW-1:0]           r_head_ptr;
    logic [IW:0]             r_count;
    logic [READ_ENTRIES-1:0] r_pending;
    logic [READ_ENTRIES-1:0] r_filled;
    logic [DATA_BITS-1:0]    r_data_mem [READ_ENTRIES];
    logic                    r_wr_done_valid;
    logic [IW-1:0]           r_wr_done_index;
    logic                    r_err_fill;

    logic                    w_alloc_ready;
    logic                    w_alloc_fire;
    logic                    w_head_filled;
    logic                    w_drain_fire;
    logic                    w_is_read;
    logic                    w_is_write;
    logic                    w_fill_slot_ok;
    logic                    w_fill_fire;
    logic                    w_fill_err;
    logic [READ_ENTRIES-1:0] w_pending_next;
    logic [READ_ENTRIES-1:0] w_filled_next;

    // ------------------------------------------------------------------------
    // Handshake decode. A slot can only be allocated while fewer than
    // READ_ENTRIES are outstanding, which also guarantees the allocation
    // slot never coincides with a head slot that is being drained.
    // ------------------------------------------------------------------------
    assign w_alloc_ready  = (r_count != FULL_COUNT);
    assign w_alloc_fire   = i_alloc_valid & w_alloc_ready;

    assign w_head_filled  = r_filled[r_head_ptr];
    assign w_drain_fire   = w_head_filled & i_out_ready;

    assign w_is_read      = i_in_valid & (i_in_type == TYPE_READ);
    assign w_is_write     = i_in_valid & (i_in_type == TYPE_WRITE);

    // A fill is only legal into an entry that was handed out and has not
    // been filled yet; anything else is dropped and flagged.
    assign w_fill_slot_ok = r_pending[i_in_index] & ~r_filled[i_in_index];
    assign w_fill_fire    = w_is_read & w_fill_slot_ok;
    assign w_fill_err     = w_is_read & ~w_fill_slot_ok;

    // ------------------------------------------------------------------------
    // Next value of the per-entry status bits. The drained head is always a
    // filled entry and a fill always targets an unfilled one, so the clear
    // and set below never land on the same bit in one cycle.
    // ------------------------------------------------------------------------
    always_comb begin
        w_pending_next = r_pending;
        w_filled_next  = r_filled;
        if (w_drain_fire) begin
            w_pending_next[r_head_ptr] = 1'b0;
            w_filled_next[r_head_ptr]  = 1'b0;
        end
        if (w_alloc_fire) begin
            w_pending_next[r_alloc_ptr] = 1'b1;
        end
        if (w_fill_fire) begin
            w_filled_next[i_in_index] = 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Status bits. Reset discards everything in flight.
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pending <= '0;
            r_filled  <= '0;
        end else begin
            r_pending <= w_pending_next;
            r_filled  <= w_filled_next;
        end
    end

    // ------------------------------------------------------------------------
    // Allocation and head pointers plus the outstanding count. Both pointers
    // wrap naturally because the depth is a power of two. An allocate and a
    // drain in the same cycle leave the count unchanged.
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_alloc_ptr <= '0;
            r_head_ptr  <= '0;
            r_count     <= '0;
        end else begin
            if (w_alloc_fire) begin
                r_alloc_ptr <= r_alloc_ptr + IW'(1);
            end
            if (w_drain_fire) begin
                r_head_ptr <= r_head_ptr + IW'(1);
            end
            case ({w_alloc_fire, w_drain_fire})
                2'b10:   r_count <= r_count + (IW+1)'(1);
                2'b01:   r_count <= r_count - (IW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Reorder data storage. Not reset: its contents only matter once the
    // matching filled bit is set, and those bits are cleared by reset.
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (w_fill_fire) begin
            r_data_mem[i_in_index] <= i_in_data;
        end
    end

    // ------------------------------------------------------------------------
    // Write completion pulse and the sticky fill error. The completion index
    // is captured only on write beats and simply holds otherwise.
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_done_valid <= 1'b0;
            r_wr_done_index <= '0;
            r_err_fill      <= 1'b0;
        end else begin
            r_wr_done_valid <= w_is_write;
            if (w_is_write) begin
                r_wr_done_index <= i_in_index;
            end
            if (w_fill_err) begin
                r_err_fill <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs, all straight from registers so the head presentation cannot
    // change until the front end takes it.
    // ------------------------------------------------------------------------
    assign o_alloc_ready   = w_alloc_ready;
    assign o_alloc_index   = r_alloc_ptr;
    assign o_out_valid     = w_head_filled;
    assign o_out_data      = r_data_mem[r_head_ptr];
    assign o_out_index     = r_head_ptr;
    assign o_wr_done_valid = r_wr_done_valid;
    assign o_wr_done_index = r_wr_done_index;
    assign o_err_fill      = r_err_fill;

endmodule

// File: tb/tb_read_returner.sv
// ----------------------------------------------------------------------------
// tb_read_returner
//
// Bench for read_returner. A driver applies directed sequences and then a
// randomized phase, one cycle at a time, and keeps a behavioural model of
// the index pool: an ordered list of outstanding indices, a per-index state
// (free / pending / filled) and the stored data. Expected grants and drains
// are queued as stimulus is issued; a separate negedge monitor pops them
// whenever the DUT completes a handshake. After every clock the driver also
// compares the registered outputs against the model.
// ----------------------------------------------------------------------------
module tb_read_returner;

    localparam int DW = 16;
    localparam int N  = 64;
    localparam int IW = 6;

    localparam bit READ  = 1'b0;
    localparam bit WRITE = 1'b1;

    localparam int ST_FREE    = 0;
    localparam int ST_PENDING = 1;
    localparam int ST_FILLED  = 2;

    logic          clk;
    logic          rstN;
    logic          allocValid;
    logic          allocReady;
    logic [IW-1:0] allocIndex;
    logic          inValid;
    logic          inType;
    logic [DW-1:0] inData;
    logic [IW-1:0] inIndex;
    logic          outValid;
    logic          outReady;
    logic [DW-1:0] outData;
    logic [IW-1:0] outIndex;
    logic          wrDoneValid;
    logic [IW-1:0] wrDoneIndex;
    logic          errFill;

    int testsRun    = 0;
    int testsFailed = 0;

    // Reference model of the index pool
    int            mState [N];
    logic [DW-1:0] mData  [N];
    int            mOrder [$];
    int            mAllocPtr;
    bit            mErr;
    bit            mWrPulse;
    int            mWrIdx;

    // Scoreboard queues filled by the driver, drained by the monitor
    logic [IW+DW-1:0] expOut   [$];
    int               expGrant [$];

    read_returner #(
        .DATA_BITS    (DW),
        .READ_ENTRIES (N)
    ) dut (
        .i_clk           (clk),
        .i_rst_n         (rstN),
        .i_alloc_valid   (allocValid),
        .o_alloc_ready   (allocReady),
        .o_alloc_index   (allocIndex),
        .i_in_valid      (inValid),
        .i_in_type       (inType),
        .i_in_data       (inData),
        .i_in_index      (inIndex),
        .o_out_valid     (outValid),
        .i_out_ready     (outReady),
        .o_out_data      (outData),
        .o_out_index     (outIndex),
        .o_wr_done_valid (wrDoneValid),
        .o_wr_done_index (wrDoneIndex),
        .o_err_fill      (errFill)
    );

    // Free-running clock, 10 time units per cycle
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: every check goes through here
    task automatic checkVal(input string name, input logic [31:0] actual,
                            input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                     name, actual, expected, $time);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < N; i++) begin
            mState[i] = ST_FREE;
        end
        mOrder.delete();
        mAllocPtr = 0;
        mErr      = 1'b0;
        mWrPulse  = 1'b0;
        mWrIdx    = 0;
        expOut.delete();
        expGrant.delete();
    endtask

    // Compare all externally visible state against the model
    task automatic checkOutput();
        bit headOk;
        int expHead;
        expHead = (mAllocPtr - mOrder.size() + N) % N;
        headOk  = (mOrder.size() > 0) && (mState[mOrder[0]] == ST_FILLED);
        checkVal("alloc_ready", allocReady, mOrder.size() != N);
        checkVal("alloc_index", allocIndex, mAllocPtr);
        checkVal("out_valid", outValid, headOk);
        checkVal("out_index", outIndex, expHead);
        if (headOk) begin
            checkVal("out_data", outData, mData[mOrder[0]]);
        end
        checkVal("wr_done_valid", wrDoneValid, mWrPulse);
        checkVal("wr_done_index", wrDoneIndex, mWrIdx);
        checkVal("err_fill", errFill, mErr);
    endtask

    // Drive one cycle of inputs, advance the model to the post-edge state,
    // then check after the edge. Called a little after a rising edge.
    task automatic applyStimulus(input bit av, input bit iv, input bit ty,
                                 input logic [DW-1:0] d, input logic [IW-1:0] ix,
                                 input bit ordy);
        bit fireA;
        bit drain;
        logic [IW-1:0] headIx;
        allocValid = av;
        inValid    = iv;
        inType     = ty;
        inData     = d;
        inIndex    = ix;
        outReady   = ordy;

        fireA = av && (mOrder.size() < N);
        drain = ordy && (mOrder.size() > 0) && (mState[mOrder[0]] == ST_FILLED);
        if (fireA) begin
            expGrant.push_back(mAllocPtr);
        end
        if (drain) begin
            headIx = IW'(mOrder[0]);
            expOut.push_back({headIx, mData[mOrder[0]]});
        end

        mWrPulse = iv && (ty == WRITE);
        if (mWrPulse) begin
            mWrIdx = int'(ix);
        end
        if (iv && (ty == READ)) begin
            if (mState[ix] == ST_PENDING) begin
                mState[ix] = ST_FILLED;
                mData[ix]  = d;
            end else begin
                mErr = 1'b1;
            end
        end
        if (drain) begin
            mState[mOrder[0]] = ST_FREE;
            void'(mOrder.pop_front());
        end
        if (fireA) begin
            mState[mAllocPtr] = ST_PENDING;
            mOrder.push_back(mAllocPtr);
            mAllocPtr = (mAllocPtr + 1) % N;
        end

        @(posedge clk);
        #1;
        checkOutput();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, 1'b0, READ, '0, '0, 1'b0);
        end
    endtask

    // Asynchronous reset applied between edges, checked before any clock
    task automatic doReset();
        rstN       = 1'b0;
        allocValid = 1'b0;
        inValid    = 1'b0;
        inType     = READ;
        inData     = '0;
        inIndex    = '0;
        outReady   = 1'b0;
        modelReset();
        #1;
        checkOutput();
        repeat (2) @(posedge clk);
        #1;
        rstN = 1'b1;
        checkOutput();
    endtask

    // Monitor: pops the scoreboard whenever the DUT completes a handshake
    always @(negedge clk) begin : monitor
        logic [IW+DW-1:0] e;
        bit drainSeen;
        bit grantSeen;
        int g;
        if (rstN) begin
            drainSeen = outValid && outReady;
            if (drainSeen || expOut.size() != 0) begin
                if (expOut.size() == 0) begin
                    checkVal("unexpected drain", 1, 0);
                end else begin
                    e = expOut.pop_front();
                    checkVal("drain handshake", drainSeen, 1);
                    if (drainSeen) begin
                        checkVal("drain index", outIndex, e[IW+DW-1:DW]);
                        checkVal("drain data", outData, e[DW-1:0]);
                    end
                end
            end
            grantSeen = allocValid && allocReady;
            if (grantSeen || expGrant.size() != 0) begin
                if (expGrant.size() == 0) begin
                    checkVal("unexpected grant", 1, 0);
                end else begin
                    g = expGrant.pop_front();
                    checkVal("grant handshake", grantSeen, 1);
                    if (grantSeen) begin
                        checkVal("grant index", allocIndex, g);
                    end
                end
            end
        end
    end

    initial begin
        int cand [$];
        int pick;
        rstN       = 1'b1;
        allocValid = 1'b0;
        inValid    = 1'b0;
        inType     = READ;
        inData     = '0;
        inIndex    = '0;
        outReady   = 1'b0;
        modelReset();
        #1;
        doReset();

        // Out-of-order fills come out in allocation order
        $display("[TB] reorder of three entries");
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, READ, '0, '0, 1'b1);
        applyStimulus(1'b0, 1'b1, READ, 16'h000C, 6'd2, 1'b1);
        applyStimulus(1'b0, 1'b1, READ, 16'h000A, 6'd0, 1'b1);
        applyStimulus(1'b0, 1'b1, READ, 16'h000B, 6'd1, 1'b1);
        idle(1);
        applyStimulus(1'b0, 1'b0, READ, '0, '0, 1'b1);
        applyStimulus(1'b0, 1'b0, READ, '0, '0, 1'b1);
        idle(1);

        // Full pool, then one drain frees a slot and the pointer wraps
        $display("[TB] full and wrap");
        doReset();
        for (int i = 0; i < N + 1; i++) applyStimulus(1'b1, 1'b0, READ, '0, '0, 1'b0);
        applyStimulus(1'b1, 1'b1, READ, 16'h0055, 6'd0, 1'b0);
        applyStimulus(1'b1, 1'b0, READ, '0, '0, 1'b1);
        applyStimulus(1'b1, 1'b0, READ, '0, '0, 1'b0);
        applyStimulus(1'b1, 1'b0, READ, '0, '0, 1'b0);

        // Back-pressure holds the head presentation
        $display("[TB] back-pressure");
        doReset();
        applyStimulus(1'b1, 1'b0, READ, '0, '0, 1'b0);
        applyStimulus(1'b0, 1'b1, READ, 16'h1234, 6'd0, 1'b0);
        idle(5);
        applyStimulus(1'b0, 1'b0, READ, '0, '0, 1'b1);
        applyStimulus(1'b0, 1'b0, READ, '0, '0, 1'b1);

        // Write completion pulse
        $display("[TB] write completion");
        applyStimulus(1'b0, 1'b1, WRITE, 16'hFFFF, 6'd9, 1'b0);
        idle(2);

        // Illegal fills: never allocated, and a second fill of one entry
        $display("[TB] fill errors");
        doReset();
        applyStimulus(1'b1, 1'b0, READ, '0, '0, 1'b0);
        applyStimulus(1'b0, 1'b1, READ, 16'h0BAD, 6'd5, 1'b0);
        applyStimulus(1'b0, 1'b1, READ, 16'h1111, 6'd0, 1'b0);
        applyStimulus(1'b0, 1'b1, READ, 16'h2222, 6'd0, 1'b0);
        applyStimulus(1'b0, 1'b0, READ, '0, '0, 1'b1);
        idle(2);

        // Reset in the middle of traffic, then normal operation again
        $display("[TB] mid-operation reset");
        doReset();
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, READ, '0, '0, 1'b0);
        applyStimulus(1'b0, 1'b1, READ, 16'h7777, 6'd1, 1'b0);
        doReset();
        applyStimulus(1'b1, 1'b0, READ, '0, '0, 1'b0);
        applyStimulus(1'b0, 1'b1, READ, 16'h4321, 6'd0, 1'b0);
        applyStimulus(1'b0, 1'b0, READ, '0, '0, 1'b1);
        idle(1);

        // Random traffic with only legal fills
        $display("[TB] random traffic");
        doReset();
        for (int c = 0; c < 2000; c++) begin
            cand.delete();
            foreach (mOrder[k]) begin
                if (mState[mOrder[k]] == ST_PENDING) cand.push_back(mOrder[k]);
            end
            if (cand.size() > 0 && ($urandom % 2) == 0) begin
                pick = cand[$urandom % cand.size()];
                applyStimulus(($urandom % 3) != 0, 1'b1, READ, DW'($urandom),
                              IW'(pick), ($urandom % 4) != 0);
            end else if (($urandom % 6) == 0) begin
                applyStimulus(($urandom % 3) != 0, 1'b1, WRITE, DW'($urandom),
                              IW'($urandom), ($urandom % 4) != 0);
            end else begin
                applyStimulus(($urandom % 3) != 0, 1'b0, READ, '0, '0,
                              ($urandom % 4) != 0);
            end
        end

        // Flush everything still outstanding, bounded
        for (int c = 0; c < 4 * N && mOrder.size() > 0; c++) begin
            cand.delete();
            foreach (mOrder[k]) begin
                if (mState[mOrder[k]] == ST_PENDING) cand.push_back(mOrder[k]);
            end
            if (cand.size() > 0) begin
                applyStimulus(1'b0, 1'b1, READ, DW'($urandom), IW'(cand[0]), 1'b1);
            end else begin
                applyStimulus(1'b0, 1'b0, READ, '0, '0, 1'b1);
            end
        end
        idle(2);
        checkVal("flush complete", mOrder.size(), 0);
        checkVal("scoreboard empty", expOut.size() + expGrant.size(), 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/read_returner.md
# read_returner

Reorder stage directly downstream of the back end's burst handler. It takes read data that returns out of order, tagged by read index, and delivers it to the front end strictly in allocation order through a valid/ready handshake. It also owns the allocation of read indices to the front end and reports write completions as single-cycle pulses.

## Interface
- DATA_BITS, 16, width of one read data beat
- READ_ENTRIES, 64, reorder depth; power of two; IW = $clog2(READ_ENTRIES)
- clk input 1: single clock, rising edge
- rst_n input 1: asynchronous active-low reset
- alloc_valid input 1: front end requests a read index
- alloc_ready output 1: an index is available (count < READ_ENTRIES)
- alloc_index output IW: index granted on an alloc_valid & alloc_ready cycle
- in_valid input 1: burst handler returner_valid
- in_type input 1: r_type from types_def (read / write)
- in_data input DATA_BITS: burst handler returner_data
- in_index input IW: burst handler returner_index
- out_valid output 1: in-order read data available
- out_ready input 1: front end accepts out_data
- out_data output DATA_BITS: read data for out_index
- out_index output IW: index of the head entry
- wr_done_valid output 1: one-cycle write completion pulse
- wr_done_index output IW: index of the completed write
- err_fill output 1: sticky; set when a fill hits a non-pending or already-filled entry

## Operation
- State:
  - alloc_ptr (IW bits)
  - head_ptr (IW bits)
  - count (IW+1 bits)
  - pending[READ_ENTRIES]
  - filled[READ_ENTRIES]
  - data_mem[READ_ENTRIES][DATA_BITS]
- Allocate: on alloc_valid & alloc_ready, pending[alloc_ptr] is set and alloc_ptr increments modulo READ_ENTRIES (natural wrap). alloc_index = alloc_ptr, combinationally.
- Fill: on in_valid with in_type == read:
  - If pending[in_index] is set and filled[in_index] is clear, write data_mem[in_index] and set filled[in_index].
  - Otherwise drop the data and set err_fill. err_fill clears only on reset.
- Write completion: on in_valid with in_type == write, register wr_done_valid = 1 and wr_done_index = in_index for exactly one cycle. Nothing is stored.
- Drain:
  - out_valid = filled[head_ptr]; out_data = data_mem[head_ptr]; out_index = head_ptr. All three are combinational from registers.
  - On out_valid & out_ready: clear pending[head_ptr] and filled[head_ptr], and increment head_ptr modulo READ_ENTRIES.
- count update:
  - +1 on allocate
  - −1 on drain
  - unchanged when both happen in the same cycle
- alloc_ready = (count != READ_ENTRIES).
- Simultaneous events:
  - A fill and a drain of different entries in the same cycle both take effect.
  - A fill to head_ptr in the cycle where the head is not yet filled becomes visible as out_valid the next cycle.
  - An allocation into the slot being drained in the same cycle cannot occur: when count == READ_ENTRIES, alloc_ready is 0 for that cycle.
- Full: alloc_ready = 0 while count == READ_ENTRIES. Allocation resumes the cycle after the first drain.
- Empty: count == 0 gives out_valid = 0.
- out_valid is held with out_data stable until out_ready is seen (no retraction).

## Timing
- Fill to out_valid latency: 1 cycle, when the filled entry is the head.
- Drain throughput: 1 entry per cycle while out_ready = 1 and consecutive entries are filled.
- Write completion latency: wr_done_valid asserts 1 cycle after the in_valid write beat.
- Allocation: 1 per cycle. alloc_index reflects the new alloc_ptr on the following cycle.
- Reset (asynchronous, rst_n = 0), mid-operation or otherwise:
  - alloc_ptr = head_ptr = count = 0; all pending and filled bits cleared.
  - Outputs: alloc_ready = 1, alloc_index = 0, out_valid = 0, out_index = 0, wr_done_valid = 0, wr_done_index = 0, err_fill = 0.
  - out_data is don't-care while out_valid = 0 (data_mem is not reset).
  - In-flight data is discarded. The first grant after reset is index 0.

## Test plan
- Allocate indices 0, 1, 2; fill 2 (0xC), then 0 (0xA), then 1 (0xB), with out_ready = 1 → out sequence is 0/0xA, 1/0xB, 2/0xC. Index 2 must not be presented before index 1; each out_valid follows its enabling fill by 1 cycle.
- Allocate 64 entries → alloc_ready = 0 while count = 64. Fill and drain index 0 → alloc_ready = 1 the next cycle, and the next grant is alloc_index 0 (wrap).
- Back-pressure: head filled with 0x1234 and out_ready = 0 for 5 cycles → out_valid stays 1 and out_data stays 0x1234. Raise out_ready → exactly one drain.
- Write beat with in_index = 9 → wr_done_valid high for exactly one cycle, 1 cycle later, with wr_done_index = 9; read state is unchanged.
- Fill index 5 when it was never allocated, or fill it twice → err_fill = 1 and stays set. The stored data for an already-filled entry is not overwritten.
- Assert rst_n = 0 with 3 entries outstanding and 1 filled → immediately out_valid = 0, alloc_ready = 1, alloc_index = 0. After release, allocate, fill and drain index 0 normally.
